// File: rtl/matrix_mult_sequencer_pkg.sv
// Shared constants, state encoding and operand-index helpers for the
// time-multiplexed 3x3 signed matrix multiply sequencer.
package matrix_mult_sequencer_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned N      = 3;
    localparam int unsigned N_ELEM = 9;
    localparam int unsigned N_OPND = 18;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned IDX_W  = 2;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    // Row-major position of element (row, col) inside one 3x3 operand
    function automatic logic [CNT_W-1:0] a_index(input logic [IDX_W-1:0] row,
                                                 input logic [IDX_W-1:0] col);
        return CNT_W'(row) * CNT_W'(N) + CNT_W'(col);
    endfunction

    // B occupies the second half of the operand file
    function automatic logic [CNT_W-1:0] b_index(input logic [IDX_W-1:0] row,
                                                 input logic [IDX_W-1:0] col);
        return CNT_W'(N_ELEM) + a_index(row, col);
    endfunction

endpackage

// File: rtl/matrix_mult_sequencer_mac.sv
// Registered signed multiply-accumulate; product and sum wrap modulo 2^DATA_W.
module mac_unit_s16
    import matrix_mult_sequencer_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [DATA_W-1:0] sum_c
);

    logic signed [DATA_W-1:0] acc;
    logic signed [DATA_W-1:0] prod;

    // Evaluating in DATA_W context keeps only the low bits of the product
    assign prod  = a * b;
    assign sum_c = acc + prod;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (en) begin
            acc <= sum_c;
        end
    end

endmodule

// File: rtl/matrix_mult_sequencer.sv
// Loads A and B over a valid/ready stream, runs nine 3-term dot products on a
// shared MAC, and streams the 3x3 product back out row-major.
module matrix_mult_sequencer
    import matrix_mult_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              abort,
    output logic              busy,
    output logic              done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
    localparam logic [CNT_W-1:0] LAST_OPND = CNT_W'(N_OPND - 1);

    state_t            state, state_n;
    logic [CNT_W-1:0]  load_cnt, load_cnt_n;
    logic [IDX_W-1:0]  i, j, k, i_n, j_n, k_n;
    logic [DATA_W-1:0] out_data_n;
    logic              in_ready_n, out_valid_n, out_last_n, busy_n, done_n;
    logic              wr_en, mac_clear, mac_en;
    logic [DATA_W-1:0] mac_sum;
    logic [DATA_W-1:0] opnd [N_OPND];

    // Operand file needs no reset: every element is rewritten before use
    always_ff @(posedge clk) begin
        if (wr_en) begin
            opnd[load_cnt] <= in_data;
        end
    end

    mac_unit_s16 u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (mac_clear),
        .en    (mac_en),
        .a     (opnd[a_index(i, k)]),
        .b     (opnd[b_index(k, j)]),
        .sum_c (mac_sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_LOAD;
            load_cnt  <= '0;
            i         <= '0;
            j         <= '0;
            k         <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            load_cnt  <= load_cnt_n;
            i         <= i_n;
            j         <= j_n;
            k         <= k_n;
            in_ready  <= in_ready_n;
            out_valid <= out_valid_n;
            out_last  <= out_last_n;
            out_data  <= out_data_n;
            busy      <= busy_n;
            done      <= done_n;
        end
    end

    // Next state plus the registered-output values derived from it
    always_comb begin
        state_n    = state;
        load_cnt_n = load_cnt;
        i_n        = i;
        j_n        = j;
        k_n        = k;
        out_data_n = out_data;
        done_n     = 1'b0;
        wr_en      = 1'b0;
        mac_clear  = 1'b0;
        mac_en     = 1'b0;

        if (abort) begin
            state_n    = ST_LOAD;
            load_cnt_n = '0;
            i_n        = '0;
            j_n        = '0;
            k_n        = '0;
            mac_clear  = 1'b1;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (in_valid && in_ready) begin
                        wr_en = 1'b1;
                        if (load_cnt == LAST_OPND) begin
                            state_n    = ST_MAC;
                            load_cnt_n = '0;
                            i_n        = '0;
                            j_n        = '0;
                            k_n        = '0;
                            mac_clear  = 1'b1;
                        end else begin
                            load_cnt_n = load_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_MAC: begin
                    if (k == LAST_IDX) begin
                        out_data_n = mac_sum;
                        k_n        = '0;
                        mac_clear  = 1'b1;
                        state_n    = ST_OUT;
                    end else begin
                        mac_en = 1'b1;
                        k_n    = k + IDX_W'(1);
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        if ((i == LAST_IDX) && (j == LAST_IDX)) begin
                            state_n = ST_LOAD;
                            done_n  = 1'b1;
                            i_n     = '0;
                            j_n     = '0;
                        end else begin
                            state_n = ST_MAC;
                            if (j == LAST_IDX) begin
                                j_n = '0;
                                i_n = i + IDX_W'(1);
                            end else begin
                                j_n = j + IDX_W'(1);
                            end
                        end
                    end
                end
                default: begin
                    state_n    = ST_LOAD;
                    load_cnt_n = '0;
                end
            endcase
        end

        in_ready_n  = (state_n == ST_LOAD);
        out_valid_n = (state_n == ST_OUT);
        out_last_n  = out_valid_n && (i_n == LAST_IDX) && (j_n == LAST_IDX);
        busy_n      = (state_n != ST_LOAD) || (load_cnt_n != '0);
    end

endmodule

// File: tb/tb_matrix_mult_sequencer.sv
// Randomized self-checking bench: a dot-product reference model and a per-cycle
// compare process, plus literal expectations for hand-computed jobs.
module tb_matrix_mult_sequencer;
    import matrix_mult_sequencer_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              out_ready = 1'b0;
    logic              abort = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_ready, out_valid, out_last, busy, done;
    logic [DATA_W-1:0] out_data;

    int checks = 0;
    int errors = 0;
    int n_done = 0;

    logic [DATA_W-1:0] job [N_OPND];
    logic [DATA_W-1:0] got_q [$];

    // Reference model state: loading vs computing, result index, cycles waited
    logic              m_loading = 1'b1;
    int                m_cnt = 0;
    int                m_res = 0;
    int                m_wait = 0;
    logic              m_done_exp = 1'b0;
    logic              m_vld;
    logic [DATA_W-1:0] m_op [N_OPND];
    logic [DATA_W-1:0] m_y [N_ELEM];

    matrix_mult_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .abort     (abort),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void golden();
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                int s = 0;
                for (int q = 0; q < 3; q++) begin
                    s += int'($signed(m_op[r*3+q])) * int'($signed(m_op[9+q*3+c]));
                end
                m_y[r*3+c] = DATA_W'(s);
            end
        end
    endfunction

    // Compare process: outputs are checked mid-cycle, then the handshakes that
    // will happen at the coming edge advance the model.
    always @(negedge clk) begin
        if (!rst_n) begin
            m_loading  = 1'b1;
            m_cnt      = 0;
            m_res      = 0;
            m_wait     = 0;
            m_done_exp = 1'b0;
        end else begin
            m_vld = !m_loading && (m_wait >= 3);
            chk("in_ready", in_ready, m_loading);
            chk("busy", busy, (!m_loading || m_cnt != 0));
            chk("done", done, m_done_exp);
            chk("out_valid", out_valid, m_vld);
            if (m_vld) begin
                chk("out_data", out_data, m_y[m_res]);
                chk("out_last", out_last, (m_res == 8));
            end
            if (done) n_done++;
            m_wait++;
            m_done_exp = 1'b0;
            if (abort) begin
                m_loading = 1'b1;
                m_cnt     = 0;
                m_wait    = 0;
            end else if (m_loading) begin
                if (in_valid) begin
                    m_op[m_cnt] = in_data;
                    m_cnt++;
                    if (m_cnt == N_OPND) begin
                        golden();
                        m_loading = 1'b0;
                        m_cnt     = 0;
                        m_res     = 0;
                        m_wait    = 0;
                    end
                end
            end else if (m_vld && out_ready) begin
                got_q.push_back(out_data);
                m_res++;
                m_wait = 0;
                if (m_res == N_ELEM) begin
                    m_loading  = 1'b1;
                    m_done_exp = 1'b1;
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_last"}, out_last, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    // Called at posedge+1; drops rst_n between edges and checks immediately
    task automatic async_reset(input string tag);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        abort     = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs(tag);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic load_job(input int gap_pct, input int rst_elem);
        int idx = 0;
        int cyc = 0;
        bit hs;
        @(posedge clk); #1;
        while (idx < N_OPND && cyc < 1000) begin
            in_valid = ($urandom_range(99) >= gap_pct);
            in_data  = job[idx];
            @(negedge clk);
            hs = in_valid && in_ready;
            @(posedge clk); #1;
            cyc++;
            if (hs) idx++;
            if (idx == rst_elem) begin
                async_reset("rst_load");
                return;
            end
        end
        in_valid = 1'b0;
        chk("load_accepted", idx, N_OPND);
    endtask

    // Modes: 0 ready always, 1 stall 5 cycles on the second result, 2 random
    task automatic drain(input int mode, input int stop_got);
        int cyc = 0;
        int stall = 5;
        while (got_q.size() < stop_got && cyc < 400) begin
            if (mode == 1 && got_q.size() == 1 && out_valid && stall > 0) begin
                out_ready = 1'b0;
                stall--;
            end else if (mode == 2) begin
                out_ready = 1'($urandom_range(1));
            end else begin
                out_ready = 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        if (cyc >= 400) chk("drain_timeout", got_q.size(), stop_got);
    endtask

    task automatic run_job(input int gap_pct, input int mode);
        int d0 = n_done;
        got_q.delete();
        load_job(gap_pct, -1);
        drain(mode, N_ELEM);
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("done_pulses", n_done - d0, 1);
        chk("result_count", got_q.size(), N_ELEM);
    endtask

    task automatic zero_job();
        for (int e = 0; e < N_OPND; e++) job[e] = '0;
    endtask

    task automatic random_job();
        for (int e = 0; e < N_OPND; e++) job[e] = DATA_W'($urandom);
    endtask

    initial begin
        int d0;
        int cyc;
        repeat (2) @(posedge clk);
        #1 check_reset_outputs("reset");
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("post_reset");

        // A = I, B = 1..9
        zero_job();
        job[0] = 16'd1; job[4] = 16'd1; job[8] = 16'd1;
        for (int e = 0; e < 9; e++) job[9+e] = DATA_W'(e + 1);
        run_job(0, 0);
        for (int n = 0; n < 9; n++) chk("identity_y", got_q[n], n + 1);

        for (int e = 0; e < N_OPND; e++) job[e] = 16'd1;
        run_job(0, 0);
        chk("ones_y11", got_q[0], 3);
        chk("ones_y33", got_q[8], 3);

        zero_job();
        job[0] = 16'hFFFE; job[9] = 16'd3;
        run_job(0, 0);
        chk("signed_y11", got_q[0], 16'hFFFA);
        chk("signed_y22", got_q[4], 0);

        zero_job();
        job[0] = 16'd300; job[9] = 16'd300;
        run_job(0, 0);
        chk("wrap_y11", got_q[0], 24464);

        zero_job();
        job[0] = 16'h8000; job[9] = 16'h8000;
        run_job(0, 0);
        chk("min_sq_y11", got_q[0], 0);

        random_job();
        run_job(30, 1);
        for (int t = 0; t < 4; t++) begin
            random_job();
            run_job(20, 2);
        end

        // Abort during MAC of Y22, then an abort racing an offered element
        random_job();
        got_q.delete();
        d0 = n_done;
        load_job(0, -1);
        drain(0, 4);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        in_valid = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; abort = 1'b0;
        chk("abort_discard_busy", busy, 0);
        repeat (4) @(posedge clk);
        #1 chk("abort_no_done", n_done - d0, 0);
        random_job();
        run_job(10, 0);

        // Reset mid-LOAD after element 7 and mid-OUT while Y13 waits
        random_job();
        got_q.delete();
        load_job(0, 7);
        random_job();
        run_job(0, 0);
        random_job();
        got_q.delete();
        load_job(0, -1);
        drain(0, 2);
        out_ready = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("y13_valid_before_reset", out_valid, 1);
        async_reset("rst_out");
        random_job();
        run_job(25, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
